// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampled 8N1 UART receiver with a 64-byte queue and a request/ready read port
module uart_rx #(
   parameter int PRESCALE = 651
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   input  logic        UART_RX
);
   localparam int P8 = 8 * PRESCALE;
   localparam int P4 = 4 * PRESCALE;
   localparam int CW = $clog2(P8);
   localparam logic [CW-1:0] C_P8 = CW'(P8 - 1);
   localparam logic [CW-1:0] C_P4 = CW'(P4 - 1);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
   state_t r_state, w_state_next;
   logic r_sync1, r_sync2, r_prev;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [2:0] r_bit, w_bit;
   logic [7:0] r_shift, w_shift;
   logic w_push, w_frame, w_tick;
   logic [7:0] r_mem [64];
   logic [5:0] r_wr_ptr, r_rd_ptr;
   logic [6:0] r_count;
   logic w_full, w_empty, w_wr, w_rd, w_ovf_set, w_rd_start;
   logic r_ovf, r_frm, r_busy, r_ready;
   logic [31:0] r_rdata;
   assign w_tick = (r_cnt == '0);
   always_comb begin
      w_state_next = r_state;
      w_cnt = w_tick ? r_cnt : r_cnt - 1'b1;
      w_bit = r_bit;
      w_shift = r_shift;
      w_push = 1'b0;
      w_frame = 1'b0;
      case (r_state)
         S_IDLE: if (r_prev && !r_sync2) begin
            w_state_next = S_START;
            w_cnt = C_P4;
         end
         S_START: if (w_tick) begin
            w_state_next = r_sync2 ? S_IDLE : S_DATA;
            w_cnt = r_sync2 ? '0 : C_P8;
            w_bit = 3'd0;
         end
         S_DATA: if (w_tick) begin
            w_shift = {r_sync2, r_shift[7:1]};
            w_cnt = C_P8;
            w_bit = r_bit + 3'd1;
            w_state_next = (r_bit == 3'd7) ? S_STOP : S_DATA;
         end
         S_STOP: if (w_tick) begin
            w_push = r_sync2;
            w_frame = !r_sync2;
            w_state_next = r_sync2 ? S_IDLE : S_BREAK;
         end
         S_BREAK: w_state_next = r_sync2 ? S_IDLE : S_BREAK;
         default: w_state_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev <= 1'b1;
         r_cnt <= '0;
         r_bit <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_next;
         r_sync1 <= UART_RX;
         r_sync2 <= r_sync1;
         r_prev <= r_sync2;
         r_cnt <= w_cnt;
         r_bit <= w_bit;
         r_shift <= w_shift;
      end
   end
   assign w_full = (r_count == 7'd64);
   assign w_empty = (r_count == 7'd0);
   assign w_wr = w_push && !w_full;
   assign w_ovf_set = w_push && w_full;
   assign w_rd_start = i_request && !r_busy;
   assign w_rd = w_rd_start && !w_empty;
   always_ff @(posedge i_clock) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_shift;
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count <= '0;
         r_ovf <= 1'b0;
         r_frm <= 1'b0;
         r_busy <= 1'b0;
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + 6'(w_wr);
         r_rd_ptr <= r_rd_ptr + 6'(w_rd);
         r_count <= r_count + 7'(w_wr) - 7'(w_rd);
         r_ovf <= w_ovf_set || (r_ovf && !w_rd_start);
         r_frm <= w_frame || (r_frm && !w_rd_start);
         r_busy <= r_busy ? i_request : w_rd_start;
         r_ready <= w_rd_start;
         if (w_rd_start) r_rdata <= {21'd0, r_frm, r_ovf, !w_empty, w_empty ? 8'd0 : r_mem[r_rd_ptr]};
      end
   end
   assign o_ready = r_ready;
   assign o_rdata = r_rdata;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed receive, glitch, framing, overflow and mid-frame reset scenarios
module tb_uart_rx;
   localparam int PRESCALE = 4;
   localparam int P8 = 8 * PRESCALE;
   logic clk = 1'b0;
   logic rst, i_request, i_uart;
   logic [31:0] o_rdata;
   logic o_ready;
   int n_pass = 0;
   int n_total = 0;
   uart_rx #(.PRESCALE(PRESCALE)) dut (
      .i_clock(clk), .i_reset(rst), .i_request(i_request),
      .o_rdata(o_rdata), .o_ready(o_ready), .UART_RX(i_uart)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask
   task automatic line_bit(input logic b);
      i_uart = b;
      repeat (P8) @(negedge clk);
   endtask
   task automatic send(input logic [7:0] d, input logic stop);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(d[i]);
      line_bit(stop);
   endtask
   task automatic rd(input string tag, input logic [31:0] expv);
      i_request = 1'b1;
      @(negedge clk);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      chk(tag, o_rdata, expv);
      i_request = 1'b0;
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(o_ready), 32'd0);
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b1;
      i_request = 1'b0;
      i_uart = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", 32'(o_ready), 32'd0);
      chk("reset_rdata", o_rdata, 32'd0);
      repeat (5) @(negedge clk);
      send(8'h55, 1'b1);
      repeat (4) @(negedge clk);
      rd("b55", 32'h155);
      rd("empty1", 32'h000);
      chk("hold_rdata", o_rdata, 32'h000);
      send(8'h41, 1'b1);
      send(8'hA3, 1'b1);
      repeat (4) @(negedge clk);
      rd("b41", 32'h141);
      rd("bA3", 32'h1A3);
      i_uart = 1'b0;
      repeat (2 * PRESCALE) @(negedge clk);
      i_uart = 1'b1;
      repeat (2 * P8) @(negedge clk);
      rd("glitch", 32'h000);
      send(8'hA3, 1'b0);
      repeat (3 * P8) @(negedge clk);
      i_uart = 1'b1;
      repeat (P8) @(negedge clk);
      rd("framing", 32'h400);
      rd("frm_clear", 32'h000);
      for (int i = 0; i <= 64; i++) send(8'(i), 1'b1);
      repeat (4) @(negedge clk);
      rd("ovf_first", 32'h300);
      for (int i = 1; i < 64; i++) rd("fifo_seq", 32'h100 | 32'(i));
      rd("ovf_empty", 32'h000);
      line_bit(1'b0);
      for (int i = 0; i < 3; i++) line_bit(1'b1);
      repeat (P8 / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 32'(o_ready), 32'd0);
      chk("midrst_rdata", o_rdata, 32'd0);
      repeat (P8 / 2 - 1) @(negedge clk);
      for (int i = 4; i < 8; i++) line_bit(1'b1);
      line_bit(1'b1);
      repeat (P8) @(negedge clk);
      rd("midrst_empty", 32'h000);
      send(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      rd("b3C", 32'h13C);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, the receive-side counterpart of the system UART transmitter. It samples the asynchronous `UART_RX` line at 8x bit rate and deframes 8N1 characters into a 64-entry byte queue. A CPU-side request/ready port drains the queue and reports sticky overflow and framing-error status. It sits on the same peripheral bus slot style as the transmitter and uses the same `PRESCALE` convention.

## Interface
- `PRESCALE`, default 50000000/(9600*8) = 651: clocks per 1/8 bit; one bit period = 8*PRESCALE clocks (P8); half bit = 4*PRESCALE (P4).
- `i_clock`  in  1  single clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_request`  in  1  read request from the bus; held high until `o_ready` is seen.
- `o_rdata`  out  32  read word: [7:0] byte, [8] valid, [9] overflow sticky, [10] framing sticky, [31:11] zero.
- `o_ready`  out  1  one-cycle pulse; `o_rdata` is valid in the same cycle.
- `UART_RX`  in  1  asynchronous serial input, idle high.

## Operation
- Synchronizer: 2-flop synchronizer on `UART_RX`, both flops reset to 1. A third register holds the previous synchronized value for edge detection. Only the synchronized value is used downstream.
- Bit counter: prescale counter wide enough for P8. Bit index 0..7, LSB first. The shift register receives bits at [7].
- FSM states:
  - IDLE: on synchronized falling edge (prev=1, cur=0), load counter with P4-1 and go to START.
  - START: when the counter reaches 0, sample the line.
    - Low: load P8-1, bit index=0, go to DATA.
    - High: treat as a glitch and return to IDLE. No flags change.
  - DATA: on each counter expiry, shift in the sample and reload P8-1. After bit 7, go to STOP.
  - STOP: on counter expiry, sample the line.
    - High: push the byte if the queue is not full; if full, drop the byte and set overflow. Go to IDLE.
    - Low: set framing, discard the byte, go to BREAK.
  - BREAK: wait until the synchronized line is 1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- Queue: 64 x 8 FIFO.
  - Push and pop in the same cycle are both honoured.
  - A push while full is dropped, and the contents are unchanged.
- Read transaction:
  - Starts when `i_request`=1 and the read port is not busy.
  - Next cycle: `o_ready`=1 for exactly one cycle, carrying the word below. Then busy stays set until `i_request` is seen 0, so one request produces exactly one read.
  - If the queue is non-empty: [8]=1, [7:0]=head byte, and the head is popped.
  - If empty: [8]=0, [7:0]=0.
  - [9] and [10] report the sticky flags at sample time. Both flags clear on that read.
  - If an error event lands in the same cycle as a clear, the flag ends up set.
- Reset, including mid-frame: FSM to IDLE, counters 0, queue emptied, flags 0, busy 0, `o_ready`=0, `o_rdata`=0, synchronizer to 1. A partial frame is discarded.

## Timing
- Let t be the cycle the synchronized falling edge is detected; the line pin is 2 cycles earlier. Sample points:
  - start check at t+P4
  - data bit k (k = 0..7) at t+P4+P8*(k+1)
  - stop bit at t+P4+9*P8
- Byte is visible in the queue the cycle after the stop sample. The FSM is in IDLE that same cycle, so back-to-back frames with no idle gap are received.
- Read latency: `i_request` sampled at cycle N gives `o_ready` and `o_rdata` at cycle N+1. `o_rdata` holds its value after the pulse until the next read.
- Throughput: one read per 3 cycles minimum (request high, ready, request low).
- Sample timing tolerates about ±4% baud mismatch (sampling at the bit centre).

## Test plan
- 0x55 sent at P8 = 5208 clocks, then read -> `o_ready` at N+1, `o_rdata`=0x00000155; a second read -> 0x00000000.
- 0x41 then 0xA3 sent with zero gap -> two reads return 0x141, then 0x1A3.
- 2*PRESCALE-cycle low glitch on an idle line -> FSM back to IDLE at t+P4; read returns 0x000; flags unchanged.
- 0xA3 sent with stop bit forced low, line held low 3*P8, then released -> one framing event only; read returns 0x400, next read returns 0x000.
- 65 bytes 0x00..0x40 sent with no reads -> first read 0x300; following 63 reads 0x101..0x13F in order; next read 0x000 (0x40 dropped).
- `i_reset` pulsed during data bit 3 of 0xFF -> no byte queued, read returns 0x000; next frame 0x3C is read back as 0x13C.
